wb_exc_ctrl: RTL
================

// Module: wb_exc_ctrl
// PURPOSE
//  Write-back stage with exception commit. Holds the instruction arriving from MEM and, in one cycle, decides one of:
//  normal commit, exception/interrupt entry, or ERTN return. Drives the CSR file (wb_ex/ecode/esubcode/pc/vaddr,
//  ertn_flush, csr read/write) and the regfile, and issues a PC redirect to IF with a req/ack handshake while flushing upstream.
// PARAMETERS
//  PC_W      32  PC / address width
//  DATA_W    32  GPR and CSR data width
//  CSR_NUM_W 14  CSR number width (= `WIDTH_CSR_NUM)
// PORTS
//  clk            in  1          clock; all state on posedge
//  resetn         in  1          reset: asynchronous assert, active-low
//  ms_to_ws_valid in  1          MEM holds a valid instruction
//  ws_allowin     out 1          WB can accept this cycle
//  ms_pc          in  PC_W       instruction PC
//  ms_exc         in  5          {ALE,BRK,SYS,INE,ADEF} flags raised upstream
//  ms_vaddr       in  PC_W       data address (for ALE)
//  ms_is_ertn     in  1          instruction is ERTN
//  ms_rf_we/waddr/wdata in 1/5/DATA_W  GPR write request
//  ms_csr_re/we   in  1/1        CSR read (csrrd/csrxchg) / write request
//  ms_csr_num     in  CSR_NUM_W  CSR number
//  ms_csr_wmask/wvalue in DATA_W/DATA_W  CSR write mask/value
//  rf_we/rf_waddr/rf_wdata out 1/5/DATA_W  GPR write port
//  csr_re/csr_we/csr_num/csr_wmask/csr_wvalue out  to CSR file; csr_rvalue in DATA_W
//  wb_ex/wb_pc/wb_ecode/wb_esubcode/wb_vaddr out 1/PC_W/6/9/PC_W  exception commit to CSR file
//  ertn_flush     out 1          ERTN commit pulse
//  has_int        in  1          pending enabled interrupt (from CSR file)
//  ex_entry/ertn_pc in PC_W      redirect targets from CSR file
//  flush_out      out 1          kill all upstream stages
//  redirect_req   out 1          PC redirect valid (registered)
//  redirect_pc    out PC_W       redirect target, stable while req=1
//  redirect_ack   in  1          IF accepted redirect
// BEHAVIOUR
//  - Reset: state=RUN, ws_valid=0, redirect_req=0, redirect_pc=0; all pulses/writes 0.
//  - Load: WB reg captures ms_* when ms_to_ws_valid && ws_allowin && !flush_out. ws_allowin = !ws_valid || state==RUN.
//  - WB latency 1: a valid entry in RUN retires the same cycle (ready_go=1). ws_valid clears unless refilled.
//  - Event eval (ws_valid && RUN). Priority INT>ADEF>INE>SYS>BRK>ALE:
//    INT ecode 0x00; ADEF 0x08/esub 0; INE 0x0D; SYS 0x0B; BRK 0x0C; ALE 0x09. esubcode 0 otherwise.
//  - Exception/int: wb_ex=1 one cycle, wb_pc=ws_pc, wb_vaddr=ws_vaddr. rf_we, csr_we, ertn_flush forced 0.
//    Latch redirect_pc<=ex_entry. Go to REDIR.
//  - ERTN (no exc/int): ertn_flush=1 one cycle; latch redirect_pc<=ertn_pc; go to REDIR.
//  - Normal: rf_we=ws_rf_we. rf_wdata = csr_re ? csr_rvalue : ws_rf_wdata. csr_we=ws_csr_we.
//    csr_re/num/wmask/wvalue come straight from the WB reg.
//  - flush_out=1 combinationally on the event cycle and for every cycle in REDIR, including the ack cycle.
//  - REDIR: redirect_req=1 from the cycle after the event; redirect_pc held.
//    ws_allowin=1 (drain), incoming discarded, ws_valid=0.
//    On redirect_ack: req=0 next cycle, state->RUN. Ack while req=0 is ignored.
//  - Same cycle as the event: has_int toggling is irrelevant once latched. New MEM data is discarded.
//  - Async reset mid-REDIR: req drops immediately, state RUN, no pulse emitted.
//  - INT sampled only when ws_valid; with no instruction in WB, interrupts wait.
// STRUCTURE
//  - width.vh gains: `ECODE_INT/ADE/ALE/SYS/BRK/INE, `ESUBCODE_ADEF, `EXC_ADEF..`EXC_ALE bit indices,
//    `WIDTH_CSR_NUM, state encoding `WS_RUN/`WS_REDIR.
//  - Sub-module exc_prio_enc: comb {has_int,exc[4:0]} -> {any, ecode[5:0], esubcode[8:0]}.
//  - Top: WB reg, 2-state FSM, redirect reg, output muxing.
// TESTING
//  - Normal add: pc=0x1c000000, rf_we=1, waddr=5, wdata=0x1234 -> rf_we pulse 1 cycle, no flush, next accepted back-to-back.
//  - SYS at pc=0x1c000010, ex_entry=0x1c008000 -> wb_ex=1, ecode=0x0B, wb_pc=0x1c000010.
//    flush_out high; req=1 with pc=0x1c008000 next cycle until ack 3 cycles later; RUN after.
//  - ADEF+ALE together, vaddr=0x3 -> ecode=0x08, esub=0; has_int=1 too -> ecode=0x00; rf_we=0.
//  - ERTN, ertn_pc=0x1c000014 -> ertn_flush 1 cycle, redirect_pc=0x1c000014; MEM valid during REDIR never commits.
//  - csrrd num=0x5, csr_rvalue=0xABCD -> rf_wdata=0xABCD, csr_we=0; csrwr with SYS flag -> csr_we stays 0.
//  - resetn low while req=1 -> req=0 immediately, ws_allowin=1 after release, no spurious wb_ex.

Source files
------------

// File: rtl/wb_exc_ctrl_pkg.sv
// Shared definitions for the write-back / exception commit stage.
// Exception codes, flag bit positions and WB state encoding.
package wb_exc_ctrl_pkg;

   localparam int WIDTH_CSR_NUM = 14;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;
   localparam logic [5:0] ECODE_INE = 6'h0D;

   localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

   localparam int EXC_ADEF = 0;
   localparam int EXC_INE  = 1;
   localparam int EXC_SYS  = 2;
   localparam int EXC_BRK  = 3;
   localparam int EXC_ALE  = 4;

   typedef enum logic {
      WS_RUN   = 1'b0,
      WS_REDIR = 1'b1
   } ws_state_e;

endpackage

// File: rtl/wb_exc_ctrl_exc_prio_enc.sv
// Exception priority encoder: interrupt first, then ADEF>INE>SYS>BRK>ALE.
// Pure combinational; the caller qualifies the result with a valid WB entry.
module exc_prio_enc
   import wb_exc_ctrl_pkg::*;
(
   input  logic       has_int,
   input  logic [4:0] exc,
   output logic       any,
   output logic [5:0] ecode,
   output logic [8:0] esubcode
);

   // pick the highest-priority pending cause
   always_comb begin
      any      = has_int | (|exc);
      ecode    = ECODE_INT;
      esubcode = '0;
      if (has_int) begin
         ecode = ECODE_INT;
      end else if (exc[EXC_ADEF]) begin
         ecode    = ECODE_ADE;
         esubcode = ESUBCODE_ADEF;
      end else if (exc[EXC_INE]) begin
         ecode = ECODE_INE;
      end else if (exc[EXC_SYS]) begin
         ecode = ECODE_SYS;
      end else if (exc[EXC_BRK]) begin
         ecode = ECODE_BRK;
      end else if (exc[EXC_ALE]) begin
         ecode = ECODE_ALE;
      end
   end

endmodule

// File: rtl/wb_exc_ctrl.sv
// Write-back stage: commits, takes exceptions/interrupts or returns via ERTN,
// then holds a registered PC redirect toward IF until it is acknowledged.
module wb_exc_ctrl
   import wb_exc_ctrl_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int CSR_NUM_W = WIDTH_CSR_NUM
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ms_to_ws_valid,
   output logic                 ws_allowin,
   input  logic [PC_W-1:0]      ms_pc,
   input  logic [4:0]           ms_exc,
   input  logic [PC_W-1:0]      ms_vaddr,
   input  logic                 ms_is_ertn,
   input  logic                 ms_rf_we,
   input  logic [4:0]           ms_rf_waddr,
   input  logic [DATA_W-1:0]    ms_rf_wdata,
   input  logic                 ms_csr_re,
   input  logic                 ms_csr_we,
   input  logic [CSR_NUM_W-1:0] ms_csr_num,
   input  logic [DATA_W-1:0]    ms_csr_wmask,
   input  logic [DATA_W-1:0]    ms_csr_wvalue,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic                 csr_re,
   output logic                 csr_we,
   output logic [CSR_NUM_W-1:0] csr_num,
   output logic [DATA_W-1:0]    csr_wmask,
   output logic [DATA_W-1:0]    csr_wvalue,
   input  logic [DATA_W-1:0]    csr_rvalue,
   output logic                 wb_ex,
   output logic [PC_W-1:0]      wb_pc,
   output logic [5:0]           wb_ecode,
   output logic [8:0]           wb_esubcode,
   output logic [PC_W-1:0]      wb_vaddr,
   output logic                 ertn_flush,
   input  logic                 has_int,
   input  logic [PC_W-1:0]      ex_entry,
   input  logic [PC_W-1:0]      ertn_pc,
   output logic                 flush_out,
   output logic                 redirect_req,
   output logic [PC_W-1:0]      redirect_pc,
   input  logic                 redirect_ack
);

   ws_state_e state, state_nxt;

   logic                 ws_valid;
   logic [PC_W-1:0]      ws_pc;
   logic [4:0]           ws_exc;
   logic [PC_W-1:0]      ws_vaddr;
   logic                 ws_is_ertn;
   logic                 ws_rf_we;
   logic [4:0]           ws_rf_waddr;
   logic [DATA_W-1:0]    ws_rf_wdata;
   logic                 ws_csr_re;
   logic                 ws_csr_we;
   logic [CSR_NUM_W-1:0] ws_csr_num;
   logic [DATA_W-1:0]    ws_csr_wmask;
   logic [DATA_W-1:0]    ws_csr_wvalue;

   logic       evt;
   logic       exc_any;
   logic       is_exc;
   logic       is_ertn;
   logic       normal;
   logic       load;
   logic       ack_take;
   logic [5:0] ecode;
   logic [8:0] esubcode;

   exc_prio_enc u_enc (
      .has_int  (has_int),
      .exc      (ws_exc),
      .any      (exc_any),
      .ecode    (ecode),
      .esubcode (esubcode)
   );

   // classify the WB entry; an entry in RUN always retires this cycle
   always_comb begin
      evt        = ws_valid && (state == WS_RUN);
      is_exc     = evt && exc_any;
      is_ertn    = evt && !exc_any && ws_is_ertn;
      normal     = evt && !exc_any && !ws_is_ertn;
      flush_out  = is_exc || is_ertn || (state == WS_REDIR);
      ws_allowin = !ws_valid || (state == WS_RUN);
      load       = ms_to_ws_valid && ws_allowin && !flush_out;
      ack_take   = redirect_req && redirect_ack;
   end

   // WB pipeline register; flushed data is dropped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid      <= 1'b0;
         ws_pc         <= '0;
         ws_exc        <= '0;
         ws_vaddr      <= '0;
         ws_is_ertn    <= 1'b0;
         ws_rf_we      <= 1'b0;
         ws_rf_waddr   <= '0;
         ws_rf_wdata   <= '0;
         ws_csr_re     <= 1'b0;
         ws_csr_we     <= 1'b0;
         ws_csr_num    <= '0;
         ws_csr_wmask  <= '0;
         ws_csr_wvalue <= '0;
      end else begin
         ws_valid <= load;
         if (load) begin
            ws_pc         <= ms_pc;
            ws_exc        <= ms_exc;
            ws_vaddr      <= ms_vaddr;
            ws_is_ertn    <= ms_is_ertn;
            ws_rf_we      <= ms_rf_we;
            ws_rf_waddr   <= ms_rf_waddr;
            ws_rf_wdata   <= ms_rf_wdata;
            ws_csr_re     <= ms_csr_re;
            ws_csr_we     <= ms_csr_we;
            ws_csr_num    <= ms_csr_num;
            ws_csr_wmask  <= ms_csr_wmask;
            ws_csr_wvalue <= ms_csr_wvalue;
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= WS_RUN;
      else         state <= state_nxt;
   end

   // enter REDIR on any event, leave on an accepted redirect
   always_comb begin
      state_nxt = state;
      unique case (state)
         WS_RUN:   if (is_exc || is_ertn) state_nxt = WS_REDIR;
         WS_REDIR: if (ack_take)          state_nxt = WS_RUN;
         default:  state_nxt = WS_RUN;
      endcase
   end

   // redirect target is latched at the event so later CSR changes don't leak in
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         redirect_req <= 1'b0;
         redirect_pc  <= '0;
      end else if (is_exc) begin
         redirect_req <= 1'b1;
         redirect_pc  <= ex_entry;
      end else if (is_ertn) begin
         redirect_req <= 1'b1;
         redirect_pc  <= ertn_pc;
      end else if (ack_take) begin
         redirect_req <= 1'b0;
      end
   end

   // commit-side outputs; exceptions and ERTN suppress all writes
   always_comb begin
      rf_we       = normal && ws_rf_we;
      rf_waddr    = ws_rf_waddr;
      rf_wdata    = ws_csr_re ? csr_rvalue : ws_rf_wdata;
      csr_re      = evt && ws_csr_re;
      csr_we      = normal && ws_csr_we;
      csr_num     = ws_csr_num;
      csr_wmask   = ws_csr_wmask;
      csr_wvalue  = ws_csr_wvalue;
      wb_ex       = is_exc;
      wb_pc       = ws_pc;
      wb_ecode    = ecode;
      wb_esubcode = esubcode;
      wb_vaddr    = ws_vaddr;
      ertn_flush  = is_ertn;
   end

endmodule
